// File: rtl/io_map_pkg.sv
// Shared CPU-bus map for the memory-mapped input port: register offsets, base address, bus widths.
package io_map_pkg;

  localparam int unsigned BUS_DW = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WIN_WORDS = 4;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEFAULT = 12'hFF0;

  typedef enum logic [1:0] {
    OFF_STATUS = 2'd0,
    OFF_PRESS  = 2'd1,
    OFF_SWITCH = 2'd2,
    OFF_MASK   = 2'd3
  } reg_off_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

  // Word offset of addr from base; wraps so addresses below base fall outside the window.
  function automatic logic [ADDR_W-1:0] win_offset(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
    return addr - base;
  endfunction

  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base);
    return win_offset(addr, base) < ADDR_W'(WIN_WORDS);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-flop synchronizer followed by a stable-count debouncer with a registered level.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  // Count only while the synchronized input disagrees with the level; the terminal count commits it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped button/switch input port with sticky press flags and a zero-latency read path.
// Build option IO_INPUT_IRQ_EN adds the MASK register and a registered press interrupt.
module io_input_port
  import io_map_pkg::*;
#(
  parameter int unsigned       NBTN            = 4,
  parameter int unsigned       NSW             = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = BASE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       bus_addr,
  input  logic [15:0]       bus_wdata,
  input  logic              bus_we,
  output logic [15:0]       bus_rdata,
  output logic              hit,
  input  logic [NBTN-1:0]   btn_raw,
  input  logic [NSW-1:0]    sw_raw,
  output logic              irq
);

  localparam int unsigned NBIT = NBTN + NSW;

  logic [NBIT-1:0]   raw_all;
  logic [NBIT-1:0]   level_all;
  logic [NBTN-1:0]   btn_level;
  logic [NSW-1:0]    sw_level;
  bus_req_t          req;
  logic [ADDR_W-1:0] off_full;
  reg_off_e          off;
  logic              wr_press;
  logic [NBTN-1:0]   btn_prev_q;
  logic [NBTN-1:0]   press_q;
  logic [NBTN-1:0]   press_d;
  logic [NBTN-1:0]   mask_rd;
  logic [BUS_DW-1:0] rdata_c;
  logic              unused_ok;

  assign raw_all = {sw_raw, btn_raw};

  for (genvar g = 0; g < NBIT; g++) begin : g_db
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_all[g]),
      .level_o (level_all[g])
    );
  end

  assign btn_level = level_all[NBTN-1:0];
  assign sw_level  = level_all[NBIT-1:NBTN];

  assign req      = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
  assign off_full = win_offset(req.addr, BASE_ADDR);
  assign off      = reg_off_e'(off_full[1:0]);
  assign hit      = in_window(req.addr, BASE_ADDR);
  assign wr_press = req.we & hit & (off == OFF_PRESS);

  // Write-1-to-clear, with a new rising edge taking priority over a clear in the same cycle.
  always_comb begin
    press_d = press_q & ~(wr_press ? req.wdata[NBTN-1:0] : {NBTN{1'b0}});
    press_d = press_d | (btn_level & ~btn_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= '0;
      press_q    <= '0;
    end else begin
      btn_prev_q <= btn_level;
      press_q    <= press_d;
    end
  end

`ifdef IO_INPUT_IRQ_EN
  logic            wr_mask;
  logic [NBTN-1:0] mask_q;
  logic [NBTN-1:0] mask_d;
  logic            irq_q;
  logic            irq_d;

  assign wr_mask = req.we & hit & (off == OFF_MASK);

  always_comb begin
    mask_d = mask_q;
    irq_d  = |(press_q & mask_q);
    if (wr_mask) begin
      mask_d = req.wdata[NBTN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Combinational read mux so the CPU sees data in the same cycle, like the RAM.
  always_comb begin
    rdata_c = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: rdata_c[NBTN-1:0] = btn_level;
        OFF_PRESS:  rdata_c[NBTN-1:0] = press_q;
        OFF_SWITCH: rdata_c[NSW-1:0]  = sw_level;
        OFF_MASK:   rdata_c[NBTN-1:0] = mask_rd;
        default:    rdata_c           = '0;
      endcase
    end
  end

  assign bus_rdata = rdata_c;

  assign unused_ok = ^{req, off_full};

endmodule

// File: tb/tb_io_input_port.sv
// Scoreboard bench for io_input_port with a history-window reference model of the debouncers.
module tb_io_input_port;

  localparam int unsigned NBTN = 4;
  localparam int unsigned NSW  = 8;
  localparam int unsigned DEB  = 4;
  localparam logic [11:0] BASE = 12'hFF0;

  logic             clk;
  logic             rst;
  logic [11:0]      bus_addr;
  logic [15:0]      bus_wdata;
  logic             bus_we;
  logic [15:0]      bus_rdata;
  logic             hit;
  logic [NBTN-1:0]  btn_raw;
  logic [NSW-1:0]   sw_raw;
  logic             irq;

  io_input_port #(
    .NBTN(NBTN), .NSW(NSW), .DEBOUNCE_CYCLES(DEB), .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .hit       (hit),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [11:0] a;
    logic [15:0] rd;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   probe  = 1'b0;

  logic [3:0]  btn_v;
  logic [7:0]  sw_v;

  // Reference model state
  logic [3:0]  m_lvl_b;
  logic [7:0]  m_lvl_s;
  logic [3:0]  m_press;
  logic [3:0]  m_mask;
  logic [3:0]  m_rose;
  logic        m_irq;
  logic [11:0] hist[$];

  function automatic void model_reset();
    m_lvl_b = '0; m_lvl_s = '0; m_press = '0; m_mask = '0; m_rose = '0; m_irq = 1'b0;
    hist.delete();
    for (int i = 0; i < int'(DEB) + 2; i++) hist.push_back(12'h000);
  endfunction

  function automatic logic m_hit(input logic [11:0] a);
    logic [11:0] o;
    o = a - BASE;
    return o < 12'd4;
  endfunction

  function automatic logic [15:0] m_read(input logic [11:0] a);
    logic [11:0] o;
    o = a - BASE;
    if (!m_hit(a)) return 16'h0000;
    case (o[1:0])
      2'd0:    return {12'h000, m_lvl_b};
      2'd1:    return {12'h000, m_press};
      2'd2:    return {8'h00, m_lvl_s};
`ifdef IO_INPUT_IRQ_EN
      default: return {12'h000, m_mask};
`else
      default: return 16'h0000;
`endif
    endcase
  endfunction

  // A level flips once the last DEB synchronized samples (raw delayed by two edges) all disagree with it.
  function automatic void model_edge(input logic [11:0] raw, input logic we,
                                     input logic [11:0] a, input logic [15:0] wd);
    logic [11:0] o;
    logic [11:0] lvl;
    logic [11:0] nl;
    logic [3:0]  clr;
    logic        all;
    o = a - BASE;
`ifdef IO_INPUT_IRQ_EN
    m_irq = |(m_press & m_mask);
    if (we && m_hit(a) && o == 12'd3) m_mask = wd[3:0];
`else
    m_irq = 1'b0;
`endif
    clr = (we && m_hit(a) && o == 12'd1) ? wd[3:0] : 4'h0;
    m_press = (m_press & ~clr) | m_rose;
    hist.push_back(raw);
    if (hist.size() > 32) void'(hist.pop_front());
    lvl = {m_lvl_s, m_lvl_b};
    nl  = lvl;
    for (int b = 0; b < 12; b++) begin
      all = 1'b1;
      for (int k = 0; k < int'(DEB); k++) begin
        if (hist[hist.size() - 3 - k][b] == lvl[b]) all = 1'b0;
      end
      if (all) nl[b] = ~lvl[b];
    end
    m_rose  = nl[3:0] & ~lvl[3:0];
    m_lvl_b = nl[3:0];
    m_lvl_s = nl[11:4];
  endfunction

  // One bus cycle: drive mid-cycle, queue the expected read, then advance the model at the edge.
  task automatic tick(input logic we, input logic [11:0] a, input logic [15:0] wd,
                      input string nm, input bit cst, input logic [15:0] cv, input logic rv);
    exp_t e;
    rst = rv;
    if (rv) model_reset();
    btn_raw   = btn_v;
    sw_raw    = sw_v;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    e.nm  = nm;
    e.a   = a;
    e.rd  = cst ? cv : m_read(a);
    e.hit = m_hit(a);
    e.irq = m_irq;
    sbq.push_back(e);
    probe = 1'b1;
    @(posedge clk);
    if (rv) model_reset();
    else    model_edge({sw_v, btn_v}, we, a, wd);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    tick(1'b0, a, 16'h0000, "model_read", 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [11:0] a, input logic [15:0] v);
    tick(1'b0, a, 16'h0000, nm, 1'b1, v, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    tick(1'b1, a, d, "write_cycle", 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(BASE + 12'($urandom_range(0, 4)));
  endtask

  always @(negedge clk) begin
    if (probe) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: DUT output sampled with no expected entry");
      end else begin
        mon_e = sbq.pop_front();
        if (bus_rdata !== mon_e.rd || hit !== mon_e.hit || irq !== mon_e.irq) begin
          n_fail++;
          $display("FAIL %s addr=%h: got rdata=%h hit=%b irq=%b, expected rdata=%h hit=%b irq=%b",
                   mon_e.nm, mon_e.a, bus_rdata, hit, irq, mon_e.rd, mon_e.hit, mon_e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_v = '0; sw_v = '0;
    btn_raw = '0; sw_raw = '0; bus_we = 1'b0; bus_addr = BASE; bus_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state: every register reads 0, window is FF0..FF3 only
    for (int i = 0; i < 5; i++)
      tick(1'b0, BASE + 12'(i), 16'h0000, "reset_read", 1'b1, 16'h0000, 1'b1);
    chk("reset_status", BASE, 16'h0000);
    chk("reset_miss", BASE + 12'd4, 16'h0000);

    // Button 0 press: STATUS at 2+4 edges, PRESS one edge later, sticky after release
    btn_v = 4'b0001;
    for (int i = 0; i < 5; i++) rd(BASE);
    chk("status_before_debounce", BASE, 16'h0000);
    chk("status_debounced", BASE, 16'h0001);
    chk("press_set", BASE + 12'd1, 16'h0001);
    idle(2);
    btn_v = 4'b0000;
    idle(10);
    chk("press_sticky", BASE + 12'd1, 16'h0001);

    // Short glitch on button 2 is rejected
    btn_v = 4'b0100;
    idle(3);
    btn_v = 4'b0000;
    idle(8);
    chk("glitch_status", BASE, 16'h0000);
    chk("glitch_press", BASE + 12'd1, 16'h0001);

    // W1C behaviour and set-over-clear priority
    btn_v = 4'b0100;
    idle(10);
    btn_v = 4'b0000;
    idle(10);
    chk("press_two_flags", BASE + 12'd1, 16'h0005);
    wr(BASE + 12'd1, 16'h0004);
    chk("press_w1c", BASE + 12'd1, 16'h0001);
    wr(BASE + 12'd1, 16'h0001);
    chk("press_cleared", BASE + 12'd1, 16'h0000);
    btn_v = 4'b0001;
    idle(6);
    wr(BASE + 12'd1, 16'h0001);
    chk("press_set_wins", BASE + 12'd1, 16'h0001);
    idle(3);
    btn_v = 4'b0000;
    idle(10);

    // Switches and read-only / out-of-window writes
    sw_v = 8'hA5;
    idle(10);
    chk("switch_level", BASE + 12'd2, 16'h00A5);
    wr(BASE + 12'd2, 16'hFFFF);
    chk("switch_ro", BASE + 12'd2, 16'h00A5);
    wr(BASE, 16'hFFFF);
    chk("status_ro", BASE, 16'h0000);
    wr(BASE + 12'd4, 16'hFFFF);
    chk("miss_no_effect", BASE + 12'd1, 16'h0001);
    chk("miss_read_zero", BASE + 12'd4, 16'h0000);

`ifdef IO_INPUT_IRQ_EN
    wr(BASE + 12'd3, 16'h0002);
    chk("mask_rw", BASE + 12'd3, 16'h0002);
    btn_v = 4'b0010;
    for (int i = 0; i < 7; i++) rd(BASE + 12'd1);
    chk("press_b1", BASE + 12'd1, 16'h0003);
    idle(2);
    btn_v = 4'b0000;
    idle(8);
    wr(BASE + 12'd1, 16'h0002);
    idle(3);
`else
    wr(BASE + 12'd3, 16'hFFFF);
    chk("mask_absent", BASE + 12'd3, 16'h0000);
`endif

    // Reset mid-debounce clears everything immediately
    btn_v = 4'b1000;
    idle(3);
    tick(1'b0, BASE + 12'd1, 16'h0000, "reset_mid_press", 1'b1, 16'h0000, 1'b1);
    tick(1'b0, BASE + 12'd2, 16'h0000, "reset_mid_switch", 1'b1, 16'h0000, 1'b1);
    tick(1'b0, BASE + 12'd3, 16'h0000, "reset_mid_mask", 1'b1, 16'h0000, 1'b1);
    chk("reset_release_status", BASE, 16'h0000);
    btn_v = 4'b0000;
    idle(8);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      int sel;
      if ($urandom_range(0, 5) == 0) begin
        sel = int'($urandom_range(0, 11));
        if (sel < 4) btn_v[sel] = ~btn_v[sel];
        else         sw_v[sel - 4] = ~sw_v[sel - 4];
      end
      if ($urandom_range(0, 299) == 0) begin
        tick(1'b0, BASE + 12'($urandom_range(0, 4)), 16'h0000, "rand_reset", 1'b0, 16'h0000, 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        tick(1'b1, BASE + 12'($urandom_range(0, 5)), 16'($urandom), "rand_write", 1'b0, 16'h0000, 1'b0);
      end else begin
        tick(1'b0, BASE - 12'd1 + 12'($urandom_range(0, 6)), 16'h0000, "rand_read", 1'b0, 16'h0000, 1'b0);
      end
    end

    probe = 1'b0;
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input responder on the CPU data bus: the read-side counterpart of the seven-segment output path.
- Synchronizes and debounces 4 push-buttons and 8 slide switches.
- Latches sticky button-press flags and returns status to the CPU over its combinational read path.
- Sits beside the 128-word RAM in the top level; the top muxes `bus_rdata` into the CPU's `data_in` when `hit` is high.

Parameters:
- NBTN, 4, number of push-buttons (1..16)
- NSW, 8, number of switches (1..16)
- DEBOUNCE_CYCLES, 50000, stable cycles required before a debounced level changes (>=2)
- BASE_ADDR, 12'hFF0, word address of register 0; decode uses a 4-word window

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bus_addr  input  12  CPU word address
- bus_wdata  input  16  CPU write data
- bus_we  input  1  CPU memory-write strobe, sampled at posedge clk
- bus_rdata  output  16  read data; combinational from `bus_addr` and registers
- hit  output  1  combinational; 1 when `bus_addr` is within BASE_ADDR..BASE_ADDR+3
- btn_raw  input  NBTN  asynchronous button pins, active-high
- sw_raw  input  NSW  asynchronous switch pins
- irq  output  1  press interrupt; see Optional Feature

Behaviour:
- Reset (async, active-high), all cleared immediately:
  - sync flops = 0
  - debounce counters = 0
  - debounced levels = 0
  - press flags = 0
  - mask = 0
  - irq = 0
  - `bus_rdata` reflects the cleared registers (0 for every register).
- Synchronizer: every raw bit passes through 2 flops; the raw-to-sync latency is 2 cycles.
- Debounce, per bit, buttons and switches alike:
  - Counter resets to 0 whenever sync == debounced.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the sync value on that edge and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Press flags (buttons only):
  - A flag is set on the cycle after the debounced level rises 0->1.
  - It is cleared by a write-1 to PRESS; write-0 bits are unaffected.
  - Simultaneous set and clear on the same bit: set wins.
- Register map (offset from BASE_ADDR). Unused upper bits read 0.
  - 0 STATUS: RO, debounced button levels in [NBTN-1:0].
  - 1 PRESS: R/W1C, sticky press flags.
  - 2 SWITCH: RO, debounced switch levels in [NSW-1:0].
  - 3 MASK: R/W, irq enable per button (see Optional Feature).
- Writes:
  - A write takes effect at posedge clk when `bus_we`=1 and `hit`=1.
  - Writes to STATUS or SWITCH are ignored.
  - When `hit`=0, writes are ignored and `bus_rdata`=0.
- Reads have zero latency, matching the RAM read.
- Reading PRESS has no side effect; the flags are cleared only by a write.
- Reset asserted mid-debounce discards the partial count; the debounced level returns to 0.

Optional Feature:
- Macro IO_INPUT_IRQ_EN.
- Defined:
  - MASK register implemented, reset 0.
  - irq = |(press & mask), registered, so it asserts 1 cycle after the flag is set.
- Undefined:
  - MASK reads 0 and writes to it are ignored.
  - irq is tied to 0.
  - No mask flops are synthesized.

Decomposition:
- Shared package `io_map_pkg`:
  - Register offset constants: OFF_STATUS=0, OFF_PRESS=1, OFF_SWITCH=2, OFF_MASK=3.
  - BASE_ADDR default.
  - Bus data width constant (16); the top-level RAM decode uses the same constants.
- One sub-module `debounce_cell`: a 2-flop synchronizer, counter, and level register for one bit, parameterized by DEBOUNCE_CYCLES. It is instantiated NBTN+NSW times via generate.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then read each offset -> `bus_rdata`=16'h0000; `hit`=1 for FF0..FF3 and 0 for FF4; irq=0.
- btn_raw[0] held high for 10 cycles -> STATUS=16'h0001 exactly 2+4 cycles after the edge; PRESS=16'h0001 one cycle later; PRESS stays 1 after the button is released.
- btn_raw[2] 3-cycle glitch -> STATUS and PRESS remain 0; the counter returns to 0.
- PRESS=16'h0005, then write 16'h0004 to FF1 -> PRESS=16'h0001. Write 16'h0001 on the same cycle as a new bit-0 press -> PRESS bit 0 stays 1.
- sw_raw=8'hA5 held stable -> SWITCH=16'h00A5 after the debounce period. Write 16'hFFFF to FF2 -> SWITCH unchanged.
- With IO_INPUT_IRQ_EN defined: MASK=16'h0002 and button 1 pressed -> irq=1 one cycle after PRESS bit 1 sets. Clearing PRESS bit 1 -> irq=0 next cycle. Assert rst mid-press -> all registers 0 immediately.
